tt_io_selftest: RTL and testbench
=================================

# tt_io_selftest

Parametrised built-in self-test harness for the user module's I/O path. On a start pulse it drives a pseudo-random stimulus sequence from a Galois LFSR into the design under test, compresses the returned response words into a MISR signature, and reports completion. It sits between the top-level I/O pins and the user logic, so the same signature check runs in the cocotb bench and on silicon.

## Interface
Parameters:
- W, 8: stimulus and response width (≥2)
- TAPS, 8'hB8: Galois feedback mask, shared by the LFSR and the MISR, W bits
- SEED, 8'h01: LFSR start value, nonzero, W bits
- LEN_W, 16: run-length counter width
- LAT, 1: DUT response latency in cycles (0..7)

Ports:
- clk  in  1  clock; single clock, all state rises on posedge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; honoured only in IDLE or DONE
- abort  in  1  synchronous abort to IDLE; priority over start
- len_in  in  LEN_W  stimulus word count, captured on an accepted start
- resp_in  in  W  DUT response
- stim_out  out  W  stimulus to the DUT
- stim_valid  out  1  stim_out carries a live stimulus word
- busy  out  1  high in RUN and DRAIN
- done  out  1  level; high in DONE
- signature  out  W  MISR contents
- golden_in  in  W  expected signature (only with SELFTEST_GOLDEN_CMP_EN)
- pass  out  1  signature == golden_in at done (only with SELFTEST_GOLDEN_CMP_EN)

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- Reset values: state IDLE, stim_out 0, stim_valid 0, busy 0, done 0, signature 0, pass 0, LFSR SEED, counter 0, latency pipe cleared.
- Accepted start in IDLE or DONE: capture len_in, LFSR←SEED, signature←0, done←0, and go to RUN. If len_in = 0, go straight to DONE with signature 0.
- RUN: each cycle, stim_out←LFSR, stim_valid←1, LFSR←(LFSR>>1) ^ (LFSR[0] ? TAPS : 0), count++. After len words have been issued, stim_valid←0, stim_out←0, and go to DRAIN.
- Latency pipe: stim_valid delayed by LAT cycles; LAT=0 samples in the same cycle. On each edge where the delayed valid is 1: signature←(sig>>1) ^ (sig[0] ? TAPS : 0) ^ resp_in.
- DRAIN → DONE on the edge that performs the last MISR update.
- DONE holds signature and done until the next accepted start, abort, or reset.
- start while busy is ignored: no restart, no length recapture.
- abort in any state: go to IDLE on the next edge; stim_valid, busy and done clear, the pipe clears, and signature holds its last value.
- Reset mid-run has the same effect as power-on reset.
- Counter arithmetic is unsigned LEN_W; len = 2^LEN_W−1 is legal; no wrap occurs within a run.

## Timing
- Start sampled at edge 0 → stimulus k is on stim_out in cycle k+1 (k = 0..len−1).
- Response to stimulus k is sampled at edge k+1+LAT.
- signature is final and done rises after edge len+LAT; busy falls at the same edge.
- len = 0: done rises after edge 1.
- pass is registered with done and is valid whenever done = 1.

## Configuration
- SELFTEST_GOLDEN_CMP_EN defined: golden_in and pass exist. At the edge entering DONE, pass←(next signature == golden_in); pass clears on start, abort and reset.
- Undefined: golden_in and pass are not present, and the block has no comparator logic.

## Test plan
- Loopback (resp_in = stim_out), LAT=0, len=3 → stim_out 0x01, 0xB8, 0x5C in cycles 1–3; signature 0x5C; done high after edge 3.
- Same stimulus with LAT=1 through a one-register delay, len=3 → signature 0x5C; done after edge 4; busy high exactly for cycles 1–4.
- len_in=0 → done after edge 1, signature 0x00, stim_valid never asserted.
- len=100, start pulsed again at cycle 40 → ignored: exactly 100 valid words and the same signature as an undisturbed run.
- abort at cycle 20 of a len=100 run → IDLE next edge, busy/done/stim_valid 0; a following start with len=3 and loopback gives signature 0x5C.
- SELFTEST_GOLDEN_CMP_EN defined, loopback len=3, golden_in=0x5C → pass=1 with done; golden_in=0x5D → pass=0.

Source files
------------

// File: rtl/tt_io_selftest.sv
// I/O-path BIST: Galois LFSR stimulus generator, latency-aligned MISR response compactor, run FSM.
// Optional golden-signature comparator (golden_in/pass) is built only with SELFTEST_GOLDEN_CMP_EN defined.
module tt_io_selftest #(
  parameter int              W     = 8,
  parameter logic [W-1:0]    TAPS  = 8'hB8,
  parameter logic [W-1:0]    SEED  = 8'h01,
  parameter int              LEN_W = 16,
  parameter int              LAT   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] len_in,
  input  logic [W-1:0]     resp_in,
  output logic [W-1:0]     stim_out,
  output logic             stim_valid,
  output logic             busy,
  output logic             done,
  output logic [W-1:0]     signature
`ifdef SELFTEST_GOLDEN_CMP_EN
  ,
  input  logic [W-1:0]     golden_in,
  output logic             pass
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic [W-1:0]     lfsr_q, lfsr_d;
  logic [W-1:0]     stim_out_q, stim_out_d;
  logic             stim_valid_q, stim_valid_d;
  logic [W-1:0]     sig_q, sig_d;
  logic             dv;
  logic             last_upd;

  function automatic logic [W-1:0] gstep(input logic [W-1:0] v);
    return (v >> 1) ^ (v[0] ? TAPS : '0);
  endfunction

  // dv marks the edge at which the response to an issued word is sampled;
  // last_upd flags the final in-flight word so DRAIN can leave on that same edge.
  generate
    if (LAT == 0) begin : g_nolat
      assign dv       = stim_valid_q;
      assign last_upd = 1'b0;
    end else begin : g_lat
      localparam logic [LAT-1:0] LOW = (LAT)'((1 << (LAT - 1)) - 1);
      logic [LAT-1:0] pipe_q, pipe_d;

      always_comb begin
        pipe_d = abort ? '0 : ((pipe_q << 1) | (LAT)'(stim_valid_q));
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pipe_q <= '0;
        else        pipe_q <= pipe_d;
      end

      assign dv       = pipe_q[LAT-1];
      assign last_upd = dv & ~stim_valid_q & ~|(pipe_q & LOW);
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    count_d      = count_q;
    lfsr_d       = lfsr_q;
    stim_out_d   = stim_out_q;
    stim_valid_d = stim_valid_q;
    sig_d        = sig_q;
    if (dv) sig_d = gstep(sig_q) ^ resp_in;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          len_d   = len_in;
          sig_d   = '0;
          // The first word goes out on the accepting edge itself.
          if (len_in != '0) begin
            stim_out_d   = SEED;
            stim_valid_d = 1'b1;
            lfsr_d       = gstep(SEED);
            count_d      = LEN_W'(1);
          end else begin
            stim_out_d   = '0;
            stim_valid_d = 1'b0;
            lfsr_d       = SEED;
            count_d      = '0;
          end
        end
      end
      RUN: begin
        if (count_q == len_q) begin
          stim_out_d   = '0;
          stim_valid_d = 1'b0;
          state_d      = (LAT == 0 || !stim_valid_q) ? DONE : DRAIN;
        end else begin
          stim_out_d = lfsr_q;
          lfsr_d     = gstep(lfsr_q);
          count_d    = count_q + LEN_W'(1);
        end
      end
      DRAIN: begin
        if (last_upd) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d      = IDLE;
      stim_out_d   = '0;
      stim_valid_d = 1'b0;
      sig_d        = sig_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      len_q        <= '0;
      count_q      <= '0;
      lfsr_q       <= SEED;
      stim_out_q   <= '0;
      stim_valid_q <= 1'b0;
      sig_q        <= '0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      count_q      <= count_d;
      lfsr_q       <= lfsr_d;
      stim_out_q   <= stim_out_d;
      stim_valid_q <= stim_valid_d;
      sig_q        <= sig_d;
    end
  end

  assign stim_out   = stim_out_q;
  assign stim_valid = stim_valid_q;
  assign signature  = sig_q;
  assign busy       = (state_q == RUN) || (state_q == DRAIN);
  assign done       = (state_q == DONE);

`ifdef SELFTEST_GOLDEN_CMP_EN
  logic pass_q, pass_d;

  always_comb begin
    pass_d = pass_q;
    if (abort || (start && (state_q == IDLE || state_q == DONE)))
      pass_d = 1'b0;
    else if (state_d == DONE && state_q != DONE)
      pass_d = (sig_d == golden_in);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pass_q <= 1'b0;
    else        pass_q <= pass_d;
  end

  assign pass = pass_q;
`endif

endmodule

// File: tb/tb_tt_io_selftest.sv
// Self-checking bench: two instances (LAT=0 with direct loopback, LAT=1 through one register)
// driven by identical table and random runs, checked against a stimulus/signature model.
module tb_tt_io_selftest;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] len_in;
  logic [7:0]  mask;
  logic [7:0]  resp0, resp1;
  logic [7:0]  stim0, stim1, sig0, sig1;
  logic        sv0, sv1, busy0, busy1, done0, done1;
`ifdef SELFTEST_GOLDEN_CMP_EN
  logic [7:0]  golden;
  logic        pass0, pass1;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] seq [0:299];

  always #5 clk = ~clk;

  // Response path model: word transformed by an XOR mask; LAT=1 copy goes through one register.
  assign resp0 = stim0 ^ mask;
  always @(posedge clk) resp1 <= stim1 ^ mask;

  tt_io_selftest #(.LAT(0)) u_lat0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .len_in(len_in),
    .resp_in(resp0), .stim_out(stim0), .stim_valid(sv0), .busy(busy0),
    .done(done0), .signature(sig0)
`ifdef SELFTEST_GOLDEN_CMP_EN
    , .golden_in(golden), .pass(pass0)
`endif
  );

  tt_io_selftest #(.LAT(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .len_in(len_in),
    .resp_in(resp1), .stim_out(stim1), .stim_valid(sv1), .busy(busy1),
    .done(done1), .signature(sig1)
`ifdef SELFTEST_GOLDEN_CMP_EN
    , .golden_in(golden), .pass(pass1)
`endif
  );

  function automatic logic [7:0] ref_step(input logic [7:0] v);
    return (v >> 1) ^ (v[0] ? 8'hB8 : 8'h00);
  endfunction

  // Signature over the first n responses (stimulus word k XOR mask).
  function automatic logic [7:0] model_sig(input int n, input logic [7:0] m);
    logic [7:0] s;
    s = 8'h00;
    for (int k = 0; k < n; k++) s = ref_step(s) ^ (seq[k] ^ m);
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One run from IDLE/DONE. restart_at/abort_at < 0 disable those events.
  task automatic run(input int len, input logic [7:0] m, input logic [7:0] exp_sig,
                     input int restart_at, input int abort_at);
    int d0, d1, last, n0, n1;
    logic       exp_v;
    logic [7:0] exp_s;
    d0 = (len == 0) ? 1 : len;
    d1 = (len == 0) ? 1 : len + 1;
    mask   = m;
    len_in = 16'(len);
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    len_in = 16'd5;
    last = (abort_at >= 0) ? abort_at : d1 + 1;
    for (int e = 0; e <= last; e++) begin
      if (e == abort_at) begin
        abort = 1'b0;
        n0 = (abort_at - 1 < len) ? abort_at - 1 : len;
        n1 = (abort_at - 2 < len) ? abort_at - 2 : len;
        chk("abort_state_lat0", {28'd0, sv0, busy0, done0, |stim0}, 32'd0);
        chk("abort_state_lat1", {28'd0, sv1, busy1, done1, |stim1}, 32'd0);
        chk("abort_sig_hold_lat0", {24'd0, sig0}, {24'd0, model_sig(n0, m)});
        chk("abort_sig_hold_lat1", {24'd0, sig1}, {24'd0, model_sig(n1, m)});
      end else begin
        exp_v = (e < len);
        exp_s = exp_v ? seq[e] : 8'h00;
        chk("cycle_lat0", {21'd0, sv0, busy0, done0, stim0},
            {21'd0, exp_v, 1'(e < d0), 1'(e >= d0), exp_s});
        chk("cycle_lat1", {21'd0, sv1, busy1, done1, stim1},
            {21'd0, exp_v, 1'(e < d1), 1'(e >= d1), exp_s});
      end
      if (e == restart_at) start = 1'b1;
      if (e + 1 == abort_at) abort = 1'b1;
      if (e < last) begin
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    if (abort_at < 0) begin
      chk("signature_lat0", {24'd0, sig0}, {24'd0, exp_sig});
      chk("signature_lat1", {24'd0, sig1}, {24'd0, exp_sig});
    end
    $display("run len=%0d mask=0x%02h restart=%0d abort=%0d sig0=0x%02h sig1=0x%02h exp=0x%02h",
             len, m, restart_at, abort_at, sig0, sig1, exp_sig);
  endtask

  typedef struct {
    int         len;
    logic [7:0] m;
    logic [7:0] sig;
  } vec_t;

  vec_t vecs [0:4];

  initial begin
    logic [7:0] v;
    int         rl;
    logic [7:0] rm;

    v = 8'h01;
    for (int k = 0; k < 300; k++) begin
      seq[k] = v;
      v = ref_step(v);
    end

    vecs[0] = '{len: 3, m: 8'h00, sig: 8'h5C};
    vecs[1] = '{len: 0, m: 8'h00, sig: 8'h00};
    vecs[2] = '{len: 1, m: 8'h00, sig: 8'h01};
    vecs[3] = '{len: 2, m: 8'h00, sig: 8'h00};
    vecs[4] = '{len: 2, m: 8'hFF, sig: 8'h38};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; len_in = 16'd0; mask = 8'h00;
`ifdef SELFTEST_GOLDEN_CMP_EN
    golden = 8'h00;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("reset_lat0", {13'd0, sig0, stim0, sv0, busy0, done0}, 32'd0);
    chk("reset_lat1", {13'd0, sig1, stim1, sv1, busy1, done1}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) run(vecs[i].len, vecs[i].m, vecs[i].sig, -1, -1);

    // Start while busy must be ignored.
    run(100, 8'h00, model_sig(100, 8'h00), 39, -1);

    // Abort mid-run, then a fresh loopback run.
    run(100, 8'h00, 8'h00, -1, 20);
    run(3, 8'h00, 8'h5C, -1, -1);

`ifdef SELFTEST_GOLDEN_CMP_EN
    golden = 8'h5C;
    run(3, 8'h00, 8'h5C, -1, -1);
    chk("pass_match_lat0", {31'd0, pass0}, 32'd1);
    chk("pass_match_lat1", {31'd0, pass1}, 32'd1);
    golden = 8'h5D;
    run(3, 8'h00, 8'h5C, -1, -1);
    chk("pass_mismatch_lat0", {31'd0, pass0}, 32'd0);
    chk("pass_mismatch_lat1", {31'd0, pass1}, 32'd0);
`endif

    for (int i = 0; i < 12; i++) begin
      rl = $urandom_range(1, 60);
      rm = 8'($urandom_range(0, 255));
      run(rl, rm, model_sig(rl, rm), -1, -1);
    end

    // Asynchronous reset in the middle of a run.
    mask = 8'h00; len_in = 16'd50; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrun_reset_lat0", {13'd0, sig0, stim0, sv0, busy0, done0}, 32'd0);
    chk("midrun_reset_lat1", {13'd0, sig1, stim1, sv1, busy1, done1}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_idle_lat0", {29'd0, sv0, busy0, done0}, 32'd0);
    chk("post_reset_idle_lat1", {29'd0, sv1, busy1, done1}, 32'd0);
    $display("midrun reset len=50 sig0=0x%02h sig1=0x%02h", sig0, sig1);

    run(3, 8'h00, 8'h5C, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not reach the end of test");
    $fatal(1, "timeout");
  end

endmodule
